hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_pkg.sv | 37 +++
 rtl/hazard_match.sv | 11 +
 rtl/hazard_unit.sv | 86 ++++++++
 tb/tb_hazard_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared optype encodings, forward selects and stage entry type
package hazard_pkg;

  // Decode drives these same encodings on hazard_optype.
  typedef enum logic [1:0] {
    NONE  = 2'b00,
    ALU   = 2'b01,
    LOAD  = 2'b10,
    STORE = 2'b11
  } optype_e;

  localparam logic [1:0] FWD_REG  = 2'd0;
  localparam logic [1:0] FWD_EX   = 2'd1;
  localparam logic [1:0] FWD_MEM  = 2'd2;
  localparam logic [1:0] FWD_LOAD = 2'd3;

  typedef struct packed {
    optype_e    optype;
    logic [4:0] rd;
    logic [4:0] rs2;
  } stage_t;

  // The youngest producer wins. An EX load cannot forward yet, so it selects the regfile.
  function automatic logic [1:0] fwd_select(input logic    ex_hit,
                                            input optype_e ex_op,
                                            input logic    mem_hit,
                                            input optype_e mem_op);
    logic [1:0] sel;
    sel = FWD_REG;
    if (ex_hit && (ex_op == ALU))        sel = FWD_EX;
    else if (ex_hit && (ex_op == LOAD))  sel = FWD_REG;
    else if (mem_hit && (mem_op == ALU)) sel = FWD_MEM;
    else if (mem_hit && (mem_op == LOAD)) sel = FWD_LOAD;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - source vs destination compare qualified by use and x0
module hazard_match (
  input  logic [4:0] rs,
  input  logic       src_use,
  input  logic [4:0] rd,
  output logic       hit
);

  assign hit = src_use && (rs == rd) && (rd != 5'd0);

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, branch flush and operand forwarding control
module hazard_unit
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic [4:0] rd_addr,
  input  logic       rs1use,
  input  logic       rs2use,
  input  logic [1:0] hazard_optype,
  input  logic       Branch,
  output logic       PC_EN_IF,
  output logic       reg_FD_EN,
  output logic       reg_FD_flush,
  output logic       reg_DE_flush,
  output logic [1:0] forward_ctrl_A,
  output logic [1:0] forward_ctrl_B,
  output logic       forward_ctrl_ls
);

  stage_t     ex_q;
  stage_t     mem_q;
  optype_e    wb_op_q;
  logic [4:0] wb_rd_q;

  logic id_is_store;
  logic rs2_eff_use;
  logic a_ex_hit, a_mem_hit, b_ex_hit, b_mem_hit;
  logic stall_a, stall_b, stall;

  assign id_is_store = (hazard_optype == STORE);
  // Stores always read rs2 as their data operand, whatever decode says.
  assign rs2_eff_use = rs2use | id_is_store;

  hazard_match u_match_a_ex (
    .rs(rs1_addr), .src_use(rs1use), .rd(ex_q.rd), .hit(a_ex_hit)
  );
  hazard_match u_match_a_mem (
    .rs(rs1_addr), .src_use(rs1use), .rd(mem_q.rd), .hit(a_mem_hit)
  );
  hazard_match u_match_b_ex (
    .rs(rs2_addr), .src_use(rs2_eff_use), .rd(ex_q.rd), .hit(b_ex_hit)
  );
  hazard_match u_match_b_mem (
    .rs(rs2_addr), .src_use(rs2_eff_use), .rd(mem_q.rd), .hit(b_mem_hit)
  );

  // Store data behind a load is patched later in MEM from WB, so it never stalls.
  assign stall_a = a_ex_hit && (ex_q.optype == LOAD);
  assign stall_b = b_ex_hit && (ex_q.optype == LOAD) && !id_is_store;
  assign stall   = stall_a | stall_b;

  assign forward_ctrl_A = fwd_select(a_ex_hit, ex_q.optype, a_mem_hit, mem_q.optype);
  assign forward_ctrl_B = fwd_select(b_ex_hit, ex_q.optype, b_mem_hit, mem_q.optype);

  assign PC_EN_IF     = !stall;
  assign reg_FD_EN    = !stall;
  assign reg_DE_flush = stall;
  // A stalled branch compared stale operands; it is re-evaluated next cycle.
  assign reg_FD_flush = Branch && !stall;

  assign forward_ctrl_ls = (mem_q.optype == STORE) && (wb_op_q == LOAD) &&
                           (wb_rd_q == mem_q.rs2) && (wb_rd_q != 5'd0);

  // WB only ever acts as a load producer, so its rs2 field is not kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '{optype: NONE, rd: 5'd0, rs2: 5'd0};
      mem_q   <= '{optype: NONE, rd: 5'd0, rs2: 5'd0};
      wb_op_q <= NONE;
      wb_rd_q <= 5'd0;
    end else begin
      wb_op_q <= mem_q.optype;
      wb_rd_q <= mem_q.rd;
      mem_q   <= ex_q;
      if (stall) begin
        ex_q <= '{optype: NONE, rd: 5'd0, rs2: 5'd0};
      end else begin
        ex_q <= '{optype: optype_e'(hazard_optype), rd: rd_addr, rs2: rs2_addr};
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed scenarios plus randomized reference-model check
module tb_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic       rs1use, rs2use;
  logic [1:0] hazard_optype;
  logic       Branch;
  logic       PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;
  logic [1:0] forward_ctrl_A, forward_ctrl_B;
  logic       forward_ctrl_ls;

  int passed = 0;
  int total  = 0;

  // {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, fwd_A, fwd_B, fwd_ls}
  logic [8:0] obs;
  assign obs = {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
                forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls};

  hazard_unit dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1use(rs1use), .rs2use(rs2use),
    .hazard_optype(hazard_optype), .Branch(Branch),
    .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
    .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OT_NONE = 2'b00, OT_ALU = 2'b01, OT_LOAD = 2'b10, OT_STORE = 2'b11;

  // Outputs with no hazard: run, no flush, regfile operands.
  localparam logic [8:0] IDLE_OBS = 9'b1_1_0_0_00_00_0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [1:0] op, input int rd, input int rs1, input logic u1,
                        input int rs2, input logic u2, input logic br);
    hazard_optype = op;
    rd_addr  = 5'(rd);
    rs1_addr = 5'(rs1);
    rs1use   = u1;
    rs2_addr = 5'(rs2);
    rs2use   = u2;
    Branch   = br;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_id(OT_NONE, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (obs !== IDLE_OBS) $display("FAIL reset_outputs actual=%b required=%b", obs, IDLE_OBS);
    else passed++;
  endtask

  task automatic test_alu_fwd();
    do_reset();
    set_id(OT_ALU, 5, 1, 1, 2, 1, 0);               // add x5,x1,x2
    tick();
    set_id(OT_ALU, 6, 5, 1, 7, 1, 0);               // add x6,x5,x7
    total++;
    if (obs !== 9'b1_1_0_0_01_00_0) $display("FAIL alu_fwd_ex actual=%b required=%b", obs, 9'b1_1_0_0_01_00_0);
    else passed++;
    tick();                                          // add x5 now in MEM
    set_id(OT_ALU, 9, 7, 1, 5, 1, 0);               // add x9,x7,x5
    total++;
    if (obs !== 9'b1_1_0_0_00_10_0) $display("FAIL alu_fwd_mem actual=%b required=%b", obs, 9'b1_1_0_0_00_10_0);
    else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(OT_LOAD, 5, 1, 1, 0, 0, 0);              // lw x5,0(x1)
    tick();
    set_id(OT_ALU, 6, 5, 1, 5, 1, 0);               // add x6,x5,x5
    total++;
    if (obs !== 9'b0_0_0_1_00_00_0) $display("FAIL load_use_stall actual=%b required=%b", obs, 9'b0_0_0_1_00_00_0);
    else passed++;
    tick();
    total++;
    if (obs !== 9'b1_1_0_0_11_11_0) $display("FAIL load_use_after actual=%b required=%b", obs, 9'b1_1_0_0_11_11_0);
    else passed++;
  endtask

  task automatic test_store_after_load();
    do_reset();
    set_id(OT_LOAD, 5, 1, 1, 0, 0, 0);              // lw x5,0(x1)
    tick();
    set_id(OT_STORE, 0, 1, 1, 5, 0, 0);             // sw x5,0(x1)
    total++;
    if (obs !== IDLE_OBS) $display("FAIL store_no_stall actual=%b required=%b", obs, IDLE_OBS);
    else passed++;
    tick();
    set_id(OT_NONE, 0, 0, 0, 0, 0, 0);
    total++;
    if (obs !== IDLE_OBS) $display("FAIL store_ls_early actual=%b required=%b", obs, IDLE_OBS);
    else passed++;
    tick();
    total++;
    if (obs !== 9'b1_1_0_0_00_00_1) $display("FAIL store_ls actual=%b required=%b", obs, 9'b1_1_0_0_00_00_1);
    else passed++;
    // Store data behind an ALU op forwards even though decode leaves rs2use low.
    do_reset();
    set_id(OT_ALU, 8, 1, 1, 0, 0, 0);               // addi x8,x1,imm
    tick();
    set_id(OT_STORE, 0, 2, 1, 8, 0, 0);             // sw x8,0(x2)
    total++;
    if (obs !== 9'b1_1_0_0_00_01_0) $display("FAIL store_alu_fwd actual=%b required=%b", obs, 9'b1_1_0_0_00_01_0);
    else passed++;
  endtask

  task automatic test_branch_stall();
    do_reset();
    set_id(OT_LOAD, 5, 1, 1, 0, 0, 0);              // lw x5
    tick();
    set_id(OT_NONE, 0, 5, 1, 0, 1, 1);              // beq x5,x0 taken
    total++;
    if (obs !== 9'b0_0_0_1_00_00_0) $display("FAIL branch_during_stall actual=%b required=%b", obs, 9'b0_0_0_1_00_00_0);
    else passed++;
    tick();
    total++;
    if (obs !== 9'b1_1_1_0_11_00_0) $display("FAIL branch_after_stall actual=%b required=%b", obs, 9'b1_1_1_0_11_00_0);
    else passed++;
  endtask

  task automatic test_x0();
    do_reset();
    set_id(OT_ALU, 0, 1, 1, 0, 0, 0);               // addi x0,x1,imm
    tick();
    set_id(OT_ALU, 6, 0, 1, 0, 1, 0);               // add x6,x0,x0
    total++;
    if (obs !== IDLE_OBS) $display("FAIL x0_alu actual=%b required=%b", obs, IDLE_OBS);
    else passed++;
    do_reset();
    set_id(OT_LOAD, 0, 1, 1, 0, 0, 0);              // lw x0
    tick();
    set_id(OT_ALU, 6, 0, 1, 0, 1, 0);
    total++;
    if (obs !== IDLE_OBS) $display("FAIL x0_load actual=%b required=%b", obs, IDLE_OBS);
    else passed++;
  endtask

  task automatic test_priority_reset();
    do_reset();
    set_id(OT_ALU, 5, 1, 1, 2, 1, 0);
    tick();
    set_id(OT_ALU, 5, 3, 1, 4, 1, 0);
    tick();
    set_id(OT_ALU, 6, 5, 1, 0, 0, 0);               // add x5 in both EX and MEM
    total++;
    if (obs !== 9'b1_1_0_0_01_00_0) $display("FAIL ex_priority actual=%b required=%b", obs, 9'b1_1_0_0_01_00_0);
    else passed++;
    set_id(OT_LOAD, 7, 1, 1, 0, 0, 0);
    tick();
    set_id(OT_ALU, 8, 7, 1, 0, 1, 0);
    total++;
    if (obs !== 9'b0_0_0_1_00_00_0) $display("FAIL pre_reset_stall actual=%b required=%b", obs, 9'b0_0_0_1_00_00_0);
    else passed++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    total++;
    if (obs !== IDLE_OBS) $display("FAIL reset_mid_stall actual=%b required=%b", obs, IDLE_OBS);
    else passed++;
  endtask

  // Reference pipeline history: index 0 = EX, 1 = MEM, 2 = WB.
  int m_op[3];
  int m_rd[3];
  int m_rs2[3];

  // Find the youngest older instruction that writes rs and decide where its value lives.
  function automatic void src_lookup(input int rs, input bit u, output logic [1:0] sel,
                                     output bit ex_load);
    bit found;
    found = 0;
    sel = 2'd0;
    ex_load = 0;
    for (int k = 0; k < 2; k++) begin
      if (!found && u && rs != 0 && m_rd[k] == rs && (m_op[k] == 1 || m_op[k] == 2)) begin
        found = 1;
        if (k == 0) begin
          if (m_op[k] == 1) sel = 2'd1;
          else ex_load = 1;
        end else begin
          sel = (m_op[k] == 1) ? 2'd2 : 2'd3;
        end
      end
    end
  endfunction

  task automatic test_random();
    logic [1:0] fa, fb;
    bit la, lb, stall, ls;
    logic [8:0] exp;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      m_op[k] = 0; m_rd[k] = 0; m_rs2[k] = 0;
    end
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      set_id(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      src_lookup(rs1_addr, rs1use, fa, la);
      src_lookup(rs2_addr, rs2use || hazard_optype == OT_STORE, fb, lb);
      stall = la || (lb && hazard_optype != OT_STORE);
      ls = (m_op[1] == 3) && (m_op[2] == 2) && (m_rd[2] == m_rs2[1]) && (m_rd[2] != 0);
      exp = {!stall, !stall, Branch && !stall, stall, fa, fb, ls};
      if (rst_n) begin
        total++;
        if (obs !== exp) $display("FAIL random_cycle_%0d actual=%b required=%b", n, obs, exp);
        else passed++;
      end
      @(posedge clk);
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) begin
          m_op[k] = 0; m_rd[k] = 0; m_rs2[k] = 0;
        end
      end else begin
        for (int k = 2; k > 0; k--) begin
          m_op[k] = m_op[k-1]; m_rd[k] = m_rd[k-1]; m_rs2[k] = m_rs2[k-1];
        end
        if (stall) begin
          m_op[0] = 0; m_rd[0] = 0; m_rs2[0] = 0;
        end else begin
          m_op[0] = int'(hazard_optype); m_rd[0] = int'(rd_addr); m_rs2[0] = int'(rs2_addr);
        end
      end
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(OT_NONE, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_store_after_load();
    test_branch_stall();
    test_x0();
    test_priority_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
